// File: rtl/main_mem_responder.sv
// Backing-memory responder: accepts line fill / writeback requests, waits a fixed
// latency, then streams one line as WORDS_PER_LINE 32-bit beats.
module main_mem_responder #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned LATENCY        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic              mem_wvalid_i,
    output logic              mem_ack_o,
    output logic              mem_wready_o,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_rvalid_o,
    output logic              mem_done_o,
    output logic              mem_busy_o
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [IDX_W-1:0] OFF_MASK  = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] base_q;
    logic             wr_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [OFF_W-1:0] beat_q;
    logic [OFF_W-1:0] beat_nxt;
    logic [31:0]      rdata_q;

    // Byte-offset and aliasing upper address bits never reach the index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[ADDR_W-1:IDX_W+2], mem_addr_i[1:0]};

    assign beat_nxt = beat_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_ack_o    = 1'b0;
        mem_wready_o = 1'b0;
        mem_rvalid_o = 1'b0;
        mem_done_o   = 1'b0;
        mem_busy_o   = (state_q != IDLE);
        mem_rdata_o  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_i) state_d = WAIT;
            end
            WAIT: begin
                // Counter is loaded with LATENCY-1 on accept, so this marks the first WAIT cycle.
                mem_ack_o = (lat_cnt_q == LAT_INIT);
                if (lat_cnt_q == '0) state_d = wr_q ? WBURST : RBURST;
            end
            RBURST: begin
                mem_rvalid_o = 1'b1;
                if (beat_q == LAST_BEAT) state_d = DONE;
            end
            WBURST: begin
                mem_wready_o = 1'b1;
                if (mem_wvalid_i && (beat_q == LAST_BEAT)) state_d = DONE;
            end
            DONE: begin
                mem_done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            wr_q      <= 1'b0;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_req_i) begin
                        base_q    <= mem_addr_i[IDX_W+1:2] & ~OFF_MASK;
                        wr_q      <= mem_wr_i;
                        lat_cnt_q <= LAT_INIT;
                        beat_q    <= '0;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end else if (!wr_q) begin
                        rdata_q <= mem[base_q];
                    end
                end
                RBURST: begin
                    beat_q  <= beat_nxt;
                    rdata_q <= (beat_q == LAST_BEAT) ? '0 : mem[base_q | IDX_W'(beat_nxt)];
                end
                WBURST: begin
                    if (mem_wvalid_i) beat_q <= beat_nxt;
                end
                DONE: begin
                    beat_q <= '0;
                end
                default: begin
                    beat_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == WBURST) && mem_wvalid_i) begin
            mem[base_q | IDX_W'(beat_q)] <= mem_wdata_i;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: writebacks, fills, aliasing, reset abort
// and request-hold behaviour, checked against hand-computed values.
module tb_main_mem_responder;

    localparam int unsigned LAT = 4;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_ack;
    logic        mem_wready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_done;
    logic        mem_busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] wbuf [4];
    bit          wpat [$];

    main_mem_responder #(
        .ADDR_W(32),
        .WORDS_PER_LINE(4),
        .DEPTH_WORDS(1024),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_req_i(mem_req),
        .mem_wr_i(mem_wr),
        .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_wvalid_i(mem_wvalid),
        .mem_ack_o(mem_ack),
        .mem_wready_o(mem_wready),
        .mem_rdata_o(mem_rdata),
        .mem_rvalid_o(mem_rvalid),
        .mem_done_o(mem_done),
        .mem_busy_o(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack"},    32'(mem_ack),    32'd0);
        check({tag, "_wready"}, 32'(mem_wready), 32'd0);
        check({tag, "_rvalid"}, 32'(mem_rvalid), 32'd0);
        check({tag, "_done"},   32'(mem_done),   32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic write_line(input string tag, input logic [31:0] addr, input bit junk_early);
        int beat = 0;
        int p    = 0;
        int cyc  = 0;
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = addr;
        @(negedge clk);
        check({tag, "_ack"},  32'(mem_ack),  32'd1);
        check({tag, "_busy"}, 32'(mem_busy), 32'd1);
        mem_req = 1'b0;
        mem_wr  = 1'b0;
        for (int i = 1; i <= int'(LAT); i++) begin
            mem_wvalid = junk_early;
            mem_wdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            check({tag, "_wready_lat"}, 32'(mem_wready), 32'(i == int'(LAT)));
            if (i > 1) check({tag, "_ack_once"}, 32'(mem_ack), 32'd0);
        end
        while (beat < 4 && cyc < 50) begin
            check({tag, "_wready_burst"}, 32'(mem_wready), 32'd1);
            check({tag, "_done_early"},   32'(mem_done),   32'd0);
            mem_wvalid = wpat[p % wpat.size()];
            p++;
            if (mem_wvalid) begin
                mem_wdata = wbuf[beat];
                beat++;
            end else begin
                mem_wdata = 32'h5A5A_0000 | 32'(cyc);
            end
            @(negedge clk);
            cyc++;
        end
        mem_wvalid = 1'b0;
        check({tag, "_beats"},     32'(beat),       32'd4);
        check({tag, "_done"},      32'(mem_done),   32'd1);
        check({tag, "_wready_dn"}, 32'(mem_wready), 32'd0);
        check({tag, "_busy_dn"},   32'(mem_busy),   32'd1);
        @(negedge clk);
        check({tag, "_idle"}, 32'(mem_busy), 32'd0);
        check_quiet({tag, "_idle"});
    endtask

    // Expected data comes from wbuf; hold_req keeps req high through the whole transaction.
    task automatic read_line(input string tag, input logic [31:0] addr, input bit hold_req);
        mem_req  = 1'b1;
        mem_wr   = 1'b0;
        mem_addr = addr;
        @(negedge clk);
        check({tag, "_ack"},    32'(mem_ack),    32'd1);
        check({tag, "_rvalid"}, 32'(mem_rvalid), 32'd0);
        if (!hold_req) mem_req = 1'b0;
        for (int i = 1; i <= int'(LAT); i++) begin
            @(negedge clk);
            check({tag, "_rvalid_lat"}, 32'(mem_rvalid), 32'(i == int'(LAT)));
            check({tag, "_wready_lat"}, 32'(mem_wready), 32'd0);
        end
        check({tag, "_rdata0"}, mem_rdata, wbuf[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_rvalid_b"}, 32'(mem_rvalid), 32'd1);
            check({tag, "_rdata"},    mem_rdata,       wbuf[k]);
        end
        @(negedge clk);
        check({tag, "_done"},      32'(mem_done),   32'd1);
        check({tag, "_rvalid_dn"}, 32'(mem_rvalid), 32'd0);
        check({tag, "_busy_dn"},   32'(mem_busy),   32'd1);
        @(negedge clk);
        check({tag, "_idle"}, 32'(mem_busy), 32'd0);
        check_quiet({tag, "_idle"});
    endtask

    initial begin
        rst        = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wvalid = 1'b0;
        wpat       = '{1'b1};

        @(negedge clk);
        check("rst_busy",  32'(mem_busy),  32'd0);
        check("rst_rdata", mem_rdata,      32'd0);
        check_quiet("rst");
        rst = 1'b1;
        @(negedge clk);

        // 1: plain writeback, with junk wvalid before wready
        wbuf = '{32'hCAFEBABE, 32'hABCDEFAB, 32'h0BADC0DE, 32'hB00100DE};
        write_line("t1_wr", 32'h0000_0C30, 1'b1);

        // 2: fill from a different offset in the same line
        read_line("t2_rd", 32'h0000_0C3C, 1'b0);

        // 3: writeback with wvalid gaps
        wbuf = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        wpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        write_line("t3_wr", 32'h0000_0200, 1'b0);
        wpat = '{1'b1};
        read_line("t3_rd", 32'h0000_0204, 1'b0);

        // 4: upper address bits alias onto the same line
        wbuf = '{32'h0101_A001, 32'h0202_A002, 32'h0303_A003, 32'h0404_A004};
        write_line("t4_wr", 32'h0000_0010, 1'b0);
        read_line("t4_rd", 32'h0000_1010, 1'b0);

        // 5: reset during RBURST beat 1
        mem_req  = 1'b1;
        mem_wr   = 1'b0;
        mem_addr = 32'h0000_0010;
        @(negedge clk);
        check("t5_ack", 32'(mem_ack), 32'd1);
        mem_req = 1'b0;
        repeat (LAT) @(negedge clk);
        check("t5_rdata0", mem_rdata, wbuf[0]);
        @(negedge clk);
        check("t5_rdata1", mem_rdata, wbuf[1]);
        #2 rst = 1'b0;
        #1;
        check("t5_busy", 32'(mem_busy),  32'd0);
        check("t5_rd0",  mem_rdata,      32'd0);
        check_quiet("t5_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_after_busy", 32'(mem_busy), 32'd0);
        check_quiet("t5_after");
        read_line("t5_rd", 32'h0000_0010, 1'b0);

        // 6a: req held through DONE, dropped once idle -> no second ack
        wbuf = '{32'hCAFEBABE, 32'hABCDEFAB, 32'h0BADC0DE, 32'hB00100DE};
        read_line("t6a_rd", 32'h0000_0C30, 1'b1);
        mem_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6a_busy", 32'(mem_busy), 32'd0);
            check_quiet("t6a_q");
        end

        // 6b: req still high in IDLE -> a second transaction is accepted
        read_line("t6b_rd1", 32'h0000_0C34, 1'b1);
        read_line("t6b_rd2", 32'h0000_0C38, 1'b0);
        repeat (3) @(negedge clk);
        check("t6b_busy", 32'(mem_busy), 32'd0);
        check_quiet("t6b_q");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
